// File: rtl/alu_seq_pkg.sv
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcode encodings and FSM state type for the
//                multi-cycle sequential ALU (alu_seq).
//                Optional divider controlled by macro ALU_SEQ_DIV_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_SLT  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_DIVU = 3'b110;
    localparam logic [2:0] OP_REMU = 3'b111;

    // DIV exists only when the divider is built in.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EXEC = 3'd1,
        MUL  = 3'd2,
`ifdef ALU_SEQ_DIV_EN
        DIV  = 3'd3,
`endif
        DONE = 3'd4
    } alu_state_e;

    // True for opcodes that run on the iterative unit.
    function automatic logic is_iter_op(input logic [2:0] op);
`ifdef ALU_SEQ_DIV_EN
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
`else
        return (op == OP_MUL);
`endif
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_if.sv
// ============================================================================
//  Module      : alu_seq_if
//  Description : Request/response bundle of the sequential ALU.
//                master : issues in_valid/opc/a/b, observes results.
//                slave  : the ALU itself.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_seq_if #(
    parameter int N = 32
) ();
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    opc;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          done;
    logic          busy;
    logic [N-1:0]  w;
    logic          zero;
    logic          err;

    modport master (
        output in_valid, opc, a, b,
        input  in_ready, done, busy, w, zero, err
    );

    modport slave (
        input  in_valid, opc, a, b,
        output in_ready, done, busy, w, zero, err
    );
endinterface

`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
// ============================================================================
//  Module      : alu_muldiv_iter
//  Description : Iterative unit shared by MUL and (optionally) DIVU/REMU.
//                One bit per cycle for N cycles after start_i; fin_o pulses
//                one cycle after the last iteration with res_o stable.
//                MUL : radix-2 shift-add, low N bits of a*b.
//                DIV : restoring division (present only with ALU_SEQ_DIV_EN).
//  Ports       : clk, rst, start_i, [div_i, rem_i], a_i, b_i -> fin_o, res_o
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_muldiv_iter #(
    parameter int N     = 32,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         start_i,
`ifdef ALU_SEQ_DIV_EN
    input  wire logic         div_i,
    input  wire logic         rem_i,
`endif
    input  wire logic [N-1:0] a_i,
    input  wire logic [N-1:0] b_i,
    output logic              fin_o,
    output logic [N-1:0]      res_o
);

    // acc_q : product accumulator (MUL) / partial remainder (DIV)
    // x_q   : multiplicand shifted left (MUL) / divisor (DIV)
    // y_q   : multiplier shifted right (MUL) / dividend->quotient (DIV)
    logic [N-1:0]     acc_q, acc_d;
    logic [N-1:0]     x_q,   x_d;
    logic [N-1:0]     y_q,   y_d;
    logic [CNT_W-1:0] cnt_q;
    logic             run_q;
    logic             fin_q;
`ifdef ALU_SEQ_DIV_EN
    logic             div_q;
    logic             rem_q;
    logic [N-1:0]     shl_d;
    logic             ge_d;
`endif

    always_comb begin
        acc_d = acc_q;
        x_d   = x_q;
        y_d   = y_q;
`ifdef ALU_SEQ_DIV_EN
        shl_d = {acc_q[N-2:0], y_q[N-1]};
        // The partial remainder is always below the divisor, so after the
        // shift a set MSB means the shifted value already exceeds any
        // N-bit divisor; the difference then fits back into N bits.
        ge_d  = acc_q[N-1] | (shl_d >= x_q);
        if (div_q) begin
            acc_d = ge_d ? (shl_d - x_q) : shl_d;
            y_d   = {y_q[N-2:0], ge_d};
        end else
`endif
        begin
            acc_d = y_q[0] ? (acc_q + x_q) : acc_q;
            x_d   = {x_q[N-2:0], 1'b0};
            y_d   = {1'b0, y_q[N-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
            fin_q <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            div_q <= 1'b0;
            rem_q <= 1'b0;
`endif
        end else if (start_i) begin
            acc_q <= '0;
            x_q   <= b_i;
            y_q   <= a_i;
            cnt_q <= CNT_W'(N - 1);
            run_q <= 1'b1;
            fin_q <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            div_q <= div_i;
            rem_q <= rem_i;
`endif
        end else if (run_q) begin
            acc_q <= acc_d;
            x_q   <= x_d;
            y_q   <= y_d;
            if (cnt_q == '0) begin
                run_q <= 1'b0;
                fin_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end else begin
            fin_q <= 1'b0;
        end
    end

    assign fin_o = fin_q;
`ifdef ALU_SEQ_DIV_EN
    assign res_o = (div_q && !rem_q) ? y_q : acc_q;
`else
    assign res_o = acc_q;
`endif

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
//  Module      : alu_seq
//  Description : Multi-cycle ALU. Single-cycle ops (ADD/SUB/AND/OR/SLT) go
//                IDLE->EXEC->DONE; MUL (and DIVU/REMU when ALU_SEQ_DIV_EN is
//                defined) iterate N cycles in alu_muldiv_iter. Without the
//                macro, DIVU/REMU complete through EXEC with w=0, err=1.
//  Ports       : clk, rst (sync, active high), bus (alu_seq_if.slave):
//                in_valid/in_ready/opc/a/b in, done/busy/w/zero/err out.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  wire logic  clk,
    input  wire logic  rst,
    alu_seq_if.slave   bus
);

    localparam int CNT_W = $clog2(N + 1);

    alu_state_e   state_q;
    logic         in_ready_q;
    logic         busy_q;
    logic         done_q;
    logic [N-1:0] w_q;
    logic         zero_q;
    logic         err_q;
    logic [N-1:0] a_q;
    logic [N-1:0] b_q;
    logic [2:0]   opc_q;

    logic [N-1:0] exec_w_d;
    logic         exec_err_d;
    logic         md_start;
    logic         md_fin;
    logic [N-1:0] md_res;

    // in_ready_q mirrors state_q == IDLE, so this is the accept strobe.
    assign md_start = in_ready_q && bus.in_valid && is_iter_op(bus.opc);

    alu_muldiv_iter #(
        .N     (N),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .start_i (md_start),
`ifdef ALU_SEQ_DIV_EN
        .div_i   (bus.opc[2] & bus.opc[1]),
        .rem_i   (bus.opc == OP_REMU),
`endif
        .a_i     (bus.a),
        .b_i     (bus.b),
        .fin_o   (md_fin),
        .res_o   (md_res)
    );

    always_comb begin
        exec_w_d   = '0;
        exec_err_d = 1'b0;
        case (opc_q)
            OP_ADD:  exec_w_d = a_q + b_q;
            OP_SUB:  exec_w_d = a_q - b_q;
            OP_AND:  exec_w_d = a_q & b_q;
            OP_OR:   exec_w_d = a_q | b_q;
            OP_SLT:  exec_w_d = {{(N-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            // Reaches EXEC only when the divider is not built in.
            OP_DIVU,
            OP_REMU: exec_err_d = 1'b1;
            default: exec_w_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            w_q        <= '0;
            zero_q     <= 1'b1;
            err_q      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            opc_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        opc_q      <= bus.opc;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (bus.opc == OP_MUL) begin
                            state_q <= MUL;
`ifdef ALU_SEQ_DIV_EN
                        end else if (bus.opc == OP_DIVU || bus.opc == OP_REMU) begin
                            state_q <= DIV;
`endif
                        end else begin
                            state_q <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    w_q     <= exec_w_d;
                    zero_q  <= ~|exec_w_d;
                    err_q   <= exec_err_d;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
`ifdef ALU_SEQ_DIV_EN
                MUL, DIV: begin
`else
                MUL: begin
`endif
                    if (md_fin) begin
                        w_q     <= md_res;
                        zero_q  <= ~|md_res;
                        err_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.w        = w_q;
    assign bus.zero     = zero_q;
    assign bus.err      = err_q;

endmodule

`default_nettype wire
